// File: rtl/shared_bv_serializer.sv
// shared_bv_serializer
//   Splits a Boolean-shared input word into NUM_PARTS parts of PART_WIDTH bits per share and
//   emits them one part per output handshake. The word is always registered first, so out_b
//   never depends combinationally on in_a. Shares are handled by separate bit-slices and are
//   never mixed.
//
//   Parameters
//     NUM_SHARES : number of Boolean shares per bit
//     PART_WIDTH : width of each emitted part, per share
//     NUM_PARTS  : parts per input word (2..16)
//     MSB_FIRST  : 0 emits part 0 first, 1 emits part NUM_PARTS-1 first
//
//   Ports
//     in_clock   : clock, rising edge
//     in_reset_n : asynchronous active-low reset
//     in_a       : shared input word, part k of share i at [i][k*PART_WIDTH +: PART_WIDTH]
//     in_valid   : in_a valid
//     in_ready   : word accepted this cycle when in_valid is also high
//     out_b      : current part, all shares
//     out_valid  : out_b valid
//     out_ready  : consumer takes out_b this cycle
//     out_index  : index k of the part on out_b
//     out_last   : current part is the final one of the word
//
//   Build option
//     SHARED_BV_SERIALIZER_CLEAR_EN : zero the word register on every return to idle
module shared_bv_serializer #(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned PART_WIDTH = 15,
  parameter int unsigned NUM_PARTS  = 2,
  parameter int unsigned MSB_FIRST  = 0
) (
  input  logic                                             in_clock,
  input  logic                                             in_reset_n,
  input  logic [NUM_SHARES-1:0][NUM_PARTS*PART_WIDTH-1:0]  in_a,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  output logic [NUM_SHARES-1:0][PART_WIDTH-1:0]            out_b,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [$clog2(NUM_PARTS)-1:0]                     out_index,
  output logic                                             out_last
);

  localparam int unsigned IdxW  = $clog2(NUM_PARTS);
  localparam int unsigned WordW = NUM_PARTS * PART_WIDTH;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PARTS - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                              state_q, state_d;
  logic [IdxW-1:0]                     cnt_q, cnt_d;
  logic [NUM_SHARES-1:0][WordW-1:0]    word_q, word_d;

  logic in_xfer;
  logic out_xfer;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // Handshake decode; a final-part transfer frees the register in the same cycle so the next
  // word can be loaded without a bubble.
  always_comb begin
    out_valid = (state_q == StBusy);
    out_last  = out_valid && (cnt_q == LastIdx);
    out_xfer  = out_valid && out_ready;
    in_ready  = (state_q == StIdle) || (out_xfer && out_last);
    in_xfer   = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    if (in_xfer) begin
      state_d = StBusy;
      cnt_d   = '0;
      word_d  = in_a;
    end else if (out_xfer) begin
      if (out_last) begin
        state_d = StIdle;
        cnt_d   = '0;
`ifdef SHARED_BV_SERIALIZER_CLEAR_EN
        word_d  = '0;
`endif
      end else begin
        cnt_d = cnt_q + IdxW'(1);
      end
    end
  end

  always_comb begin
    out_index = (MSB_FIRST != 0) ? (LastIdx - cnt_q) : cnt_q;
  end

  // Per-share part mux; each share selects only from its own slice of the register.
  always_comb begin
    out_b = '0;
    for (int unsigned i = 0; i < NUM_SHARES; i++) begin
      for (int unsigned k = 0; k < NUM_PARTS; k++) begin
        if (out_index == IdxW'(k)) begin
          out_b[i] = word_q[i][k*PART_WIDTH +: PART_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_shared_bv_serializer.sv
module tb_shared_bv_serializer;

  logic             clk;
  logic             rst_n;
  logic [1:0][31:0] in_a;
  logic             in_valid;
  logic             out_ready;

  logic             in_ready,  in_ready_m;
  logic [1:0][7:0]  out_b,     out_b_m;
  logic             out_valid, out_valid_m;
  logic [1:0]       out_index, out_index_m;
  logic             out_last,  out_last_m;

  int n_tests = 0;
  int n_fail  = 0;

  // Parts of the two test words as {share1, share0}
  logic [15:0] a_parts [4] = '{16'hAA11, 16'hBB22, 16'hCC33, 16'hDD44};
  logic [15:0] b_parts [4] = '{16'h3C55, 16'h2D66, 16'h1E77, 16'h0F88};

  shared_bv_serializer #(
    .NUM_SHARES(2), .PART_WIDTH(8), .NUM_PARTS(4), .MSB_FIRST(0)
  ) u_lsb (
    .in_clock  (clk),
    .in_reset_n(rst_n),
    .in_a      (in_a),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_b     (out_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last)
  );

  shared_bv_serializer #(
    .NUM_SHARES(2), .PART_WIDTH(8), .NUM_PARTS(4), .MSB_FIRST(1)
  ) u_msb (
    .in_clock  (clk),
    .in_reset_n(rst_n),
    .in_a      (in_a),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .out_b     (out_b_m),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .out_index (out_index_m),
    .out_last  (out_last_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a();
    in_a[0] = 32'h44332211;
    in_a[1] = 32'hDDCCBBAA;
  endtask

  task automatic load_b();
    in_a[0] = 32'h88776655;
    in_a[1] = 32'h0F1E2D3C;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_a      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_valid",   32'(out_valid),   32'd0);
    check("rst_b",       32'(out_b),       32'd0);
    check("rst_index",   32'(out_index),   32'd0);
    check("rst_last",    32'(out_last),    32'd0);
    check("rst_ready",   32'(in_ready),    32'd1);
    check("rst_index_m", 32'(out_index_m), 32'd3);
    check("rst_b_m",     32'(out_b_m),     32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single word, LSB-first and MSB-first instances side by side
    load_a();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_a     = '1;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      check($sformatf("t1_valid%0d", p),   32'(out_valid),   32'd1);
      check($sformatf("t1_b%0d", p),       32'(out_b),       32'(a_parts[p]));
      check($sformatf("t1_index%0d", p),   32'(out_index),   32'(p));
      check($sformatf("t1_last%0d", p),    32'(out_last),    32'(p == 3));
      check($sformatf("t1_valid_m%0d", p), 32'(out_valid_m), 32'd1);
      check($sformatf("t1_b_m%0d", p),     32'(out_b_m),     32'(a_parts[3-p]));
      check($sformatf("t1_index_m%0d", p), 32'(out_index_m), 32'(3 - p));
      check($sformatf("t1_last_m%0d", p),  32'(out_last_m),  32'(p == 3));
      step();
    end
    @(negedge clk);
    check("t1_idle_valid", 32'(out_valid), 32'd0);
    check("t1_idle_ready", 32'(in_ready),  32'd1);
`ifdef SHARED_BV_SERIALIZER_CLEAR_EN
    check("t1_idle_b",   32'(out_b),   32'h0000);
    check("t1_idle_b_m", 32'(out_b_m), 32'h0000);
`else
    check("t1_idle_b",   32'(out_b),   32'hAA11);
    check("t1_idle_b_m", 32'(out_b_m), 32'hDD44);
`endif
    step();

    // Backpressure on part 1, with a competing word offered while stalled
    load_a();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_b0", 32'(out_b), 32'(a_parts[0]));
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    load_b();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t2_hold_b%0d", c),     32'(out_b),     32'hBB22);
      check($sformatf("t2_hold_idx%0d", c),   32'(out_index), 32'd1);
      check($sformatf("t2_hold_valid%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("t2_hold_rdy%0d", c),   32'(in_ready),  32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int p = 1; p < 4; p++) begin
      @(negedge clk);
      check($sformatf("t2_b%0d", p),   32'(out_b),     32'(a_parts[p]));
      check($sformatf("t2_idx%0d", p), 32'(out_index), 32'(p));
      step();
    end
    @(negedge clk);
    check("t2_idle_valid", 32'(out_valid), 32'd0);
    step();

    // Back-to-back words with in_valid held high
    load_a();
    in_valid = 1'b1;
    step();
    load_b();
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      check($sformatf("t3_a_valid%0d", p), 32'(out_valid), 32'd1);
      check($sformatf("t3_a_b%0d", p),     32'(out_b),     32'(a_parts[p]));
      check($sformatf("t3_a_rdy%0d", p),   32'(in_ready),  32'(p == 3));
      step();
    end
    in_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      check($sformatf("t3_b_valid%0d", p), 32'(out_valid), 32'd1);
      check($sformatf("t3_b_b%0d", p),     32'(out_b),     32'(b_parts[p]));
      check($sformatf("t3_b_idx%0d", p),   32'(out_index), 32'(p));
      step();
    end
    @(negedge clk);
    check("t3_idle_valid", 32'(out_valid), 32'd0);
`ifdef SHARED_BV_SERIALIZER_CLEAR_EN
    check("t3_idle_b", 32'(out_b), 32'h0000);
`else
    check("t3_idle_b", 32'(out_b), 32'h3C55);
`endif
    step();

    // Reset while part 1 is on the output
    load_a();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    check("t4_pre_b", 32'(out_b), 32'(a_parts[1]));
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid",   32'(out_valid),   32'd0);
    check("t4_rst_b",       32'(out_b),       32'd0);
    check("t4_rst_idx",     32'(out_index),   32'd0);
    check("t4_rst_last",    32'(out_last),    32'd0);
    check("t4_rst_idx_m",   32'(out_index_m), 32'd3);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_ready",   32'(in_ready),   32'd1);
    check("t4_ready_m", 32'(in_ready_m), 32'd1);
    step();
    load_b();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_next_b",   32'(out_b),     32'(b_parts[0]));
    check("t4_next_idx", 32'(out_index), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
